// File: rtl/avalon_rmst_engine.sv
// Avalon-MM burst read master: splits a word-length transfer into bursts and pushes beats into a load FIFO.
// Defining AVALON_RMST_ENGINE_CHK_EN adds a sticky err output for stray beats and misaligned start addresses.
module avalon_rmst_engine #(
  parameter int DW        = 32,
  parameter int AW        = 12,
  parameter int BW        = 7,
  parameter int MAX_BURST = 64
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          trans_start,
  input  logic [DW-1:0] trans_raddr,
  input  logic [AW-1:0] trans_iolen,
  output logic          trans_done,
  output logic          busy,
  output logic [DW-1:0] avm_address,
  output logic          avm_read,
  output logic [BW-1:0] avm_burstcount,
  input  logic          avm_waitrequest,
  input  logic [DW-1:0] avm_readdata,
  input  logic          avm_readdatavalid,
  output logic [DW-1:0] fifo_wdata,
  output logic          fifo_push,
  input  logic          fifo_almost_full
`ifdef AVALON_RMST_ENGINE_CHK_EN
  ,
  output logic          err
`endif
);

  typedef enum logic [1:0] {IDLE, ISSUE, RECV, DONE} state_t;

  state_t        state_q, state_d;
  logic [DW-1:0] cur_addr_q, cur_addr_d;
  logic [AW-1:0] remaining_q, remaining_d;
  logic [BW-1:0] beat_cnt_q, beat_cnt_d;
  logic [BW-1:0] burst_len_q, burst_len_d;
  logic          avm_read_q, avm_read_d;
  logic [DW-1:0] avm_addr_q, avm_addr_d;
  logic [BW-1:0] avm_bc_q, avm_bc_d;
  logic          push_q, push_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic          done_q, done_d;
  logic          busy_q, busy_d;
  logic [AW-1:0] rem_after;
  logic          last_beat;
`ifdef AVALON_RMST_ENGINE_CHK_EN
  logic          err_q, err_d;
`endif

  // Beats in the next burst: whatever is left, capped at MAX_BURST.
  function automatic logic [BW-1:0] burst_of(input logic [AW-1:0] rem);
    logic [31:0] rem32;
    rem32 = 32'(rem);
    if (rem32 > 32'(MAX_BURST)) return BW'(MAX_BURST);
    return BW'(rem);
  endfunction

  assign rem_after = remaining_q - AW'(burst_len_q);
  assign last_beat = (beat_cnt_q == burst_len_q - BW'(1));

  always_comb begin
    state_d     = state_q;
    cur_addr_d  = cur_addr_q;
    remaining_d = remaining_q;
    beat_cnt_d  = beat_cnt_q;
    burst_len_d = burst_len_q;
    avm_read_d  = avm_read_q;
    avm_addr_d  = avm_addr_q;
    avm_bc_d    = avm_bc_q;
    push_d      = 1'b0;
    wdata_d     = wdata_q;
    done_d      = 1'b0;
    busy_d      = done_q ? 1'b0 : busy_q;
`ifdef AVALON_RMST_ENGINE_CHK_EN
    err_d       = err_q;
    if (avm_readdatavalid && (state_q != RECV)) err_d = 1'b1;
`endif
    case (state_q)
      IDLE: begin
        if (trans_start) begin
          cur_addr_d  = trans_raddr;
          remaining_d = trans_iolen;
          busy_d      = 1'b1;
          state_d     = (trans_iolen != '0) ? ISSUE : DONE;
`ifdef AVALON_RMST_ENGINE_CHK_EN
          if (trans_raddr[1:0] != 2'b00) err_d = 1'b1;
`endif
        end
      end
      ISSUE: begin
        // Once presented, a request holds until accepted regardless of FIFO level.
        if (avm_read_q) begin
          if (!avm_waitrequest) begin
            avm_read_d = 1'b0;
            beat_cnt_d = '0;
            state_d    = RECV;
          end
        end else if (!fifo_almost_full) begin
          avm_read_d  = 1'b1;
          avm_addr_d  = cur_addr_q;
          avm_bc_d    = burst_of(remaining_q);
          burst_len_d = burst_of(remaining_q);
        end
      end
      RECV: begin
        if (avm_readdatavalid) begin
          push_d  = 1'b1;
          wdata_d = avm_readdata;
          if (last_beat) begin
            cur_addr_d  = cur_addr_q + (DW'(burst_len_q) << 2);
            remaining_d = rem_after;
            state_d     = (rem_after == '0) ? DONE : ISSUE;
          end else begin
            beat_cnt_d = beat_cnt_q + BW'(1);
          end
        end
      end
      DONE: begin
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cur_addr_q  <= '0;
      remaining_q <= '0;
      beat_cnt_q  <= '0;
      burst_len_q <= '0;
      avm_read_q  <= 1'b0;
      avm_addr_q  <= '0;
      avm_bc_q    <= '0;
      push_q      <= 1'b0;
      wdata_q     <= '0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cur_addr_q  <= cur_addr_d;
      remaining_q <= remaining_d;
      beat_cnt_q  <= beat_cnt_d;
      burst_len_q <= burst_len_d;
      avm_read_q  <= avm_read_d;
      avm_addr_q  <= avm_addr_d;
      avm_bc_q    <= avm_bc_d;
      push_q      <= push_d;
      wdata_q     <= wdata_d;
      done_q      <= done_d;
      busy_q      <= busy_d;
    end
  end

`ifdef AVALON_RMST_ENGINE_CHK_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) err_q <= 1'b0;
    else     err_q <= err_d;
  end
  assign err = err_q;
`endif

  assign avm_read       = avm_read_q;
  assign avm_address    = avm_addr_q;
  assign avm_burstcount = avm_bc_q;
  assign fifo_push      = push_q;
  assign fifo_wdata     = wdata_q;
  assign trans_done     = done_q;
  assign busy           = busy_q;

endmodule

// File: tb/tb_avalon_rmst_engine.sv
// Bench for avalon_rmst_engine: Avalon slave model with random stalls/gaps, scoreboard of bursts and pushed data.
module tb_avalon_rmst_engine;
  localparam int DW = 32, AW = 12, BW = 7, MAXB = 64;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          trans_start = 1'b0;
  logic [DW-1:0] trans_raddr = '0;
  logic [AW-1:0] trans_iolen = '0;
  logic          trans_done, busy;
  logic [DW-1:0] avm_address;
  logic          avm_read;
  logic [BW-1:0] avm_burstcount;
  logic          avm_waitrequest = 1'b0;
  logic [DW-1:0] avm_readdata = '0;
  logic          avm_readdatavalid = 1'b0;
  logic [DW-1:0] fifo_wdata;
  logic          fifo_push;
  logic          fifo_almost_full = 1'b0;
`ifdef AVALON_RMST_ENGINE_CHK_EN
  logic          err;
`endif

  avalon_rmst_engine #(.DW(DW), .AW(AW), .BW(BW), .MAX_BURST(MAXB)) dut (
    .clk(clk), .rst(rst), .trans_start(trans_start), .trans_raddr(trans_raddr),
    .trans_iolen(trans_iolen), .trans_done(trans_done), .busy(busy),
    .avm_address(avm_address), .avm_read(avm_read), .avm_burstcount(avm_burstcount),
    .avm_waitrequest(avm_waitrequest), .avm_readdata(avm_readdata),
    .avm_readdatavalid(avm_readdatavalid), .fifo_wdata(fifo_wdata), .fifo_push(fifo_push),
    .fifo_almost_full(fifo_almost_full)
`ifdef AVALON_RMST_ENGINE_CHK_EN
    , .err(err)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0, n_fail = 0;

  // Monitor records and slave state
  int            cyc = 0, done_cnt = 0, done_cyc = -1, start_cyc = -1, last_push_cyc = -1;
  int            read_cycles = 0, lat_viol = 0, busy_viol = 0, stab_viol = 0, af_viol = 0;
  logic [31:0]   push_data[$];
  logic [31:0]   acc_addr[$];
  int            acc_cnt[$];
  logic [31:0]   beat_q[$];
  logic [31:0]   exp_addr[$];
  int            exp_cnt[$];
  logic [31:0]   exp_data[$];
  logic [31:0]   seed = 32'h1234_5678;
  logic          exp_busy = 1'b0, cur_real = 1'b0, last_real = 1'b0;
  logic          prev_read = 1'b0, prev_wr = 1'b0, prev_af = 1'b0;
  logic [31:0]   prev_addr = '0;
  logic [BW-1:0] prev_bc = '0;
  int            wr_hold = 0, gap_pct = 0, stray_beats = 0;
  bit            wr_rand = 1'b0;

  function automatic logic [31:0] dval(input logic [31:0] a, input logic [31:0] s);
    return (a * 32'h9E37_79B1) ^ s;
  endfunction

  // Reference: the words of the transfer, and the burst list cut at MAXB beats.
  task automatic build_exp(input logic [31:0] a0, input int len);
    logic [31:0] a;
    int rem, n;
    exp_addr.delete(); exp_cnt.delete(); exp_data.delete();
    for (int i = 0; i < len; i++) exp_data.push_back(dval(a0 + 32'(4 * i), seed));
    a = a0;
    rem = len;
    while (rem > 0) begin
      n = (rem > MAXB) ? MAXB : rem;
      exp_addr.push_back(a);
      exp_cnt.push_back(n);
      a = a + 32'(4 * n);
      rem = rem - n;
    end
  endtask

  function automatic int burst_errs();
    int e = 0;
    if (acc_addr.size() != exp_addr.size()) e++;
    for (int i = 0; i < acc_addr.size() && i < exp_addr.size(); i++)
      if (acc_addr[i] !== exp_addr[i] || acc_cnt[i] != exp_cnt[i]) e++;
    return e;
  endfunction

  function automatic int data_errs();
    int e = 0;
    if (push_data.size() != exp_data.size()) e++;
    for (int i = 0; i < push_data.size() && i < exp_data.size(); i++)
      if (push_data[i] !== exp_data[i]) e++;
    return e;
  endfunction

  // Observe at negedge, drive slave responses #1 after posedge.
  always begin
    @(negedge clk);
    if (rst) begin
      beat_q.delete();
      last_real = 1'b0; cur_real = 1'b0; exp_busy = 1'b0;
      prev_read = 1'b0; prev_wr = 1'b0; prev_af = 1'b0;
    end else begin
      cyc++;
      if (fifo_push !== last_real) lat_viol++;
      last_real = cur_real;
      if (fifo_push === 1'b1) begin
        push_data.push_back(fifo_wdata);
        last_push_cyc = cyc;
      end
      if (busy !== exp_busy) busy_viol++;
      if (trans_done === 1'b1) begin
        done_cnt++;
        done_cyc = cyc;
        exp_busy = 1'b0;
      end
      if (trans_start && !exp_busy) begin
        exp_busy = 1'b1;
        start_cyc = cyc;
      end
      if (avm_read === 1'b1) begin
        read_cycles++;
        if (prev_read && prev_wr && (avm_address !== prev_addr || avm_burstcount !== prev_bc)) stab_viol++;
        if (!prev_read && prev_af) af_viol++;
        if (!avm_waitrequest) begin
          acc_addr.push_back(avm_address);
          acc_cnt.push_back(int'(avm_burstcount));
          for (int k = 0; k < int'(avm_burstcount); k++)
            beat_q.push_back(dval(avm_address + 32'(4 * k), seed));
        end
      end
      prev_read = (avm_read === 1'b1);
      prev_wr   = avm_waitrequest;
      prev_addr = avm_address;
      prev_bc   = avm_burstcount;
      prev_af   = fifo_almost_full;
    end
    @(posedge clk);
    #1;
    if (rst) begin
      avm_waitrequest = 1'b0;
      avm_readdatavalid = 1'b0;
      cur_real = 1'b0;
    end else begin
      if (avm_read && wr_hold > 0) begin
        avm_waitrequest = 1'b1;
        wr_hold--;
      end else begin
        avm_waitrequest = wr_rand ? ($urandom_range(0, 99) < 40) : 1'b0;
      end
      cur_real = 1'b0;
      if (stray_beats > 0) begin
        avm_readdatavalid = 1'b1;
        avm_readdata = $urandom;
        stray_beats--;
      end else if (beat_q.size() > 0 && int'($urandom_range(0, 99)) >= gap_pct) begin
        avm_readdatavalid = 1'b1;
        avm_readdata = beat_q.pop_front();
        cur_real = 1'b1;
      end else begin
        avm_readdatavalid = 1'b0;
        avm_readdata = $urandom;
      end
    end
  end

  task automatic clear_mon;
    @(posedge clk); #1;
    push_data.delete(); acc_addr.delete(); acc_cnt.delete();
    done_cnt = 0; read_cycles = 0; lat_viol = 0; busy_viol = 0; stab_viol = 0; af_viol = 0;
    done_cyc = -1; start_cyc = -1; last_push_cyc = -1;
  endtask

  task automatic start_trans(input logic [31:0] a, input int len);
    @(posedge clk); #1;
    trans_start = 1'b1; trans_raddr = a; trans_iolen = AW'(len);
    @(posedge clk); #1;
    trans_start = 1'b0; trans_raddr = $urandom; trans_iolen = AW'($urandom);
  endtask

  task automatic wait_done(input int target, input int limit, output bit ok);
    int t = 0;
    while (done_cnt < target && t < limit) begin @(posedge clk); t++; end
    ok = (done_cnt >= target);
  endtask

  task automatic wait_pushes(input int target, input int limit, output bit ok);
    int t = 0;
    while (push_data.size() < target && t < limit) begin @(posedge clk); t++; end
    ok = (push_data.size() >= target);
  endtask

  task automatic test_reset;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if ({avm_read, fifo_push, trans_done, busy} !== 4'b0) begin
      n_fail++; $display("FAIL reset_ctrl: got %b, expected 0000", {avm_read, fifo_push, trans_done, busy});
    end
    n_checks++;
    if (avm_address !== '0 || avm_burstcount !== '0 || fifo_wdata !== '0) begin
      n_fail++; $display("FAIL reset_data: got addr %0h bc %0d wdata %0h, expected 0", avm_address, avm_burstcount, fifo_wdata);
    end
`ifdef AVALON_RMST_ENGINE_CHK_EN
    n_checks++;
    if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b, expected 0", err); end
`endif
    @(posedge clk); #2;
    rst = 1'b0;
    repeat (3) @(posedge clk);
  endtask

  task automatic test_single_burst;
    bit ok;
    clear_mon();
    wr_rand = 0; gap_pct = 0; seed = $urandom;
    build_exp(32'h0008_0000, 16);
    start_trans(32'h0008_0000, 16);
    wait_done(1, 500, ok);
    repeat (3) @(posedge clk);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL single_done: got %0d dones, expected 1", done_cnt); end
    n_checks++;
    if (acc_addr.size() != 1 || acc_addr[0] !== 32'h0008_0000 || acc_cnt[0] != 16) begin
      n_fail++; $display("FAIL single_burst: got %0d bursts, expected 1 at 80000 x16", acc_addr.size());
    end
    n_checks++;
    if (data_errs() != 0) begin
      n_fail++; $display("FAIL single_data: got %0d pushes %0d errors, expected 16 pushes 0 errors", push_data.size(), data_errs());
    end
    n_checks++;
    if (done_cyc != last_push_cyc + 1) begin
      n_fail++; $display("FAIL single_done_timing: got cycle %0d, expected %0d", done_cyc, last_push_cyc + 1);
    end
    n_checks++;
    if (lat_viol != 0 || busy_viol != 0) begin
      n_fail++; $display("FAIL single_push_busy: got lat %0d busy %0d violations, expected 0", lat_viol, busy_viol);
    end
  endtask

  task automatic test_split_burst;
    bit ok;
    logic [31:0] base;
    clear_mon();
    wr_rand = 1; gap_pct = 30; seed = $urandom;
    base = 32'h0001_0400;
    build_exp(base, 144);
    start_trans(base, 144);
    wait_done(1, 3000, ok);
    repeat (3) @(posedge clk);
    n_checks++;
    if (!ok || done_cnt != 1) begin n_fail++; $display("FAIL split_done: got %0d dones, expected 1", done_cnt); end
    n_checks++;
    if (acc_addr.size() != 3 || acc_addr[1] !== base + 32'd256 || acc_addr[2] !== base + 32'd512 || acc_cnt[2] != 16) begin
      n_fail++; $display("FAIL split_shape: got %0d bursts, expected 3 (64/64/16)", acc_addr.size());
    end
    n_checks++;
    if (burst_errs() != 0 || data_errs() != 0) begin
      n_fail++; $display("FAIL split_data: got %0d burst errs %0d data errs, expected 0", burst_errs(), data_errs());
    end
    n_checks++;
    if (lat_viol != 0 || busy_viol != 0 || stab_viol != 0) begin
      n_fail++; $display("FAIL split_protocol: got lat %0d busy %0d stab %0d, expected 0", lat_viol, busy_viol, stab_viol);
    end
  endtask

  task automatic test_waitrequest;
    bit ok;
    clear_mon();
    wr_rand = 0; gap_pct = 0; seed = $urandom; wr_hold = 5;
    build_exp(32'h0000_2000, 16);
    start_trans(32'h0000_2000, 16);
    wait_done(1, 500, ok);
    repeat (2) @(posedge clk);
    n_checks++;
    if (read_cycles != 6) begin n_fail++; $display("FAIL wait_read_cycles: got %0d, expected 6", read_cycles); end
    n_checks++;
    if (stab_viol != 0) begin n_fail++; $display("FAIL wait_stable: got %0d changes, expected 0", stab_viol); end
    n_checks++;
    if (!ok || burst_errs() != 0 || data_errs() != 0) begin
      n_fail++; $display("FAIL wait_complete: got done %0d data errs %0d, expected 1 and 0", done_cnt, data_errs());
    end
  endtask

  task automatic test_almost_full;
    bit ok;
    clear_mon();
    wr_rand = 0; gap_pct = 20; seed = $urandom;
    @(posedge clk); #1; fifo_almost_full = 1'b1;
    build_exp(32'h0000_4000, 80);
    start_trans(32'h0000_4000, 80);
    repeat (20) @(posedge clk);
    n_checks++;
    if (read_cycles != 0 || busy !== 1'b1) begin
      n_fail++; $display("FAIL af_hold: got %0d read cycles busy %b, expected 0 and 1", read_cycles, busy);
    end
    #1; fifo_almost_full = 1'b0;
    wait_pushes(10, 500, ok);
    #1; fifo_almost_full = 1'b1;
    wait_pushes(64, 500, ok);
    repeat (20) @(posedge clk);
    n_checks++;
    if (push_data.size() != 64 || acc_addr.size() != 1) begin
      n_fail++; $display("FAIL af_recv: got %0d pushes %0d bursts, expected 64 and 1", push_data.size(), acc_addr.size());
    end
    #1; fifo_almost_full = 1'b0;
    wait_done(1, 1000, ok);
    repeat (2) @(posedge clk);
    n_checks++;
    if (!ok || burst_errs() != 0 || data_errs() != 0 || af_viol != 0) begin
      n_fail++; $display("FAIL af_complete: got done %0d data errs %0d af viol %0d, expected 1 0 0", done_cnt, data_errs(), af_viol);
    end
  endtask

  task automatic test_zero_length;
    bit ok;
    clear_mon();
    start_trans(32'h0000_8000, 0);
    wait_done(1, 50, ok);
    repeat (3) @(posedge clk);
    n_checks++;
    if (!ok || done_cyc - start_cyc != 2) begin
      n_fail++; $display("FAIL zero_done: got delay %0d, expected 2", done_cyc - start_cyc);
    end
    n_checks++;
    if (read_cycles != 0 || push_data.size() != 0 || busy_viol != 0) begin
      n_fail++; $display("FAIL zero_bus: got %0d reads %0d pushes %0d busy errs, expected 0", read_cycles, push_data.size(), busy_viol);
    end
  endtask

  task automatic test_ignore_start;
    bit ok;
    clear_mon();
    wr_rand = 0; gap_pct = 10; seed = $urandom;
    build_exp(32'h0000_C000, 40);
    start_trans(32'h0000_C000, 40);
    repeat (6) @(posedge clk);
    start_trans(32'h0003_0000, 5);
    wait_done(1, 1000, ok);
    repeat (10) @(posedge clk);
    n_checks++;
    if (!ok || done_cnt != 1 || burst_errs() != 0 || data_errs() != 0) begin
      n_fail++; $display("FAIL ignore_start: got %0d dones %0d burst errs %0d data errs, expected 1 0 0", done_cnt, burst_errs(), data_errs());
    end
  endtask

  task automatic test_random;
    bit ok;
    logic [31:0] a;
    int len;
    for (int it = 0; it < 8; it++) begin
      clear_mon();
      wr_rand = (it % 2) == 1;
      gap_pct = $urandom_range(0, 50);
      seed = $urandom;
      a = $urandom;
      a[1:0] = 2'b00;
      if (it == 0) a = 32'hFFFF_FF00;
      len = $urandom_range(1, 200);
      build_exp(a, len);
      start_trans(a, len);
      wait_done(1, 5000, ok);
      repeat ($urandom_range(2, 4)) @(posedge clk);
      n_checks++;
      if (!ok || done_cnt != 1) begin n_fail++; $display("FAIL rand%0d_done: got %0d dones, expected 1", it, done_cnt); end
      n_checks++;
      if (burst_errs() != 0) begin
        n_fail++; $display("FAIL rand%0d_bursts: got %0d bursts %0d errs, expected %0d bursts", it, acc_addr.size(), burst_errs(), exp_addr.size());
      end
      n_checks++;
      if (data_errs() != 0) begin
        n_fail++; $display("FAIL rand%0d_data: got %0d pushes %0d errs, expected %0d pushes", it, push_data.size(), data_errs(), len);
      end
      n_checks++;
      if (done_cyc != last_push_cyc + 1 || lat_viol != 0 || busy_viol != 0 || stab_viol != 0) begin
        n_fail++; $display("FAIL rand%0d_protocol: got done %0d last push %0d lat %0d busy %0d stab %0d, expected +1 and 0", it, done_cyc, last_push_cyc, lat_viol, busy_viol, stab_viol);
      end
    end
  endtask

  task automatic test_reset_mid_recv;
    bit ok;
    int pushes_at_rst;
    clear_mon();
    wr_rand = 0; gap_pct = 0; seed = $urandom;
    start_trans(32'h0000_1000, 32);
    wait_pushes(5, 200, ok);
    @(posedge clk); #3;
    rst = 1'b1;
    pushes_at_rst = push_data.size();
    #1;
    n_checks++;
    if ({avm_read, fifo_push, trans_done, busy} !== 4'b0 || avm_address !== '0 || avm_burstcount !== '0 || fifo_wdata !== '0) begin
      n_fail++; $display("FAIL midrst_outputs: got read %b push %b done %b busy %b addr %0h, expected all 0", avm_read, fifo_push, trans_done, busy, avm_address);
    end
    @(posedge clk); #2;
    rst = 1'b0;
    stray_beats = 3;
    repeat (8) @(posedge clk);
    n_checks++;
    if (push_data.size() != pushes_at_rst || lat_viol != 0) begin
      n_fail++; $display("FAIL midrst_stray: got %0d pushes, expected %0d", push_data.size(), pushes_at_rst);
    end
    n_checks++;
    if (done_cnt != 0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL midrst_abandon: got %0d dones busy %b, expected 0 and 0", done_cnt, busy);
    end
`ifdef AVALON_RMST_ENGINE_CHK_EN
    n_checks++;
    if (err !== 1'b1) begin n_fail++; $display("FAIL midrst_err: got %b, expected 1", err); end
`endif
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_burst();
    test_split_burst();
    test_waitrequest();
    test_almost_full();
    test_zero_length();
    test_ignore_start();
    test_random();
    test_reset_mid_recv();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
